tmds_channel_decoder: RTL and testbench
=======================================

# tmds_channel_decoder

Receive-side counterpart of the per-channel TMDS encoder inside the transmitter. It accepts one 10-bit parallel TMDS word per pixel clock from the channel deserializer and finds the 10-bit word boundary by searching for DVI control tokens, using an internal barrel shifter rather than deserializer bitslip. It then decodes each aligned word into 8-bit pixel data, two control bits and a data-enable flag. One instance runs per colour channel in the future HDMI input path, on the recovered pixel clock.

## Interface
- TOKEN_COUNT, 8: consecutive control-token words needed to declare lock.
- TIMEOUT, 4096: cycles without any control token before the block advances the offset (SEARCH) or drops lock (LOCKED). Must be at least 4.
- clk  in  1  recovered pixel clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- raw  in  10  deserialized word, one per cycle; raw[0] is the earliest received bit.
- data  out  8  decoded pixel byte; 0 when de=0 or locked=0.
- c  out  2  control bits {C1,C0}; valid when de=0; 0 when locked=0.
- de  out  1  1 when the current word is a data period (non-token).
- locked  out  1  word alignment established.
- offset  out  4  current bit offset, 0..9.

## Operation
- **Window.**
  - prev holds raw from the previous cycle.
  - The aligned word is {raw, prev}[offset +: 10]; bit 0 of the 20-bit vector is prev[0].
  - The word is registered as win.
- **Tokens** (win[9:0]):
  - 10'b1101010100 → c=00
  - 10'b0010101011 → c=01
  - 10'b0101010100 → c=10
  - 10'b1010101011 → c=11
  - Any other value is a data word.
- **Decode** (data words): d = win[9] ? ~win[7:0] : win[7:0]; data[0]=d[0]; for i=1..7, data[i] = win[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1]).
- **Token words:** de=0, data=0, c from the token table. Data words: de=1, c holds its last token value.
- **Counters.**
  - tok_cnt (saturating at TOKEN_COUNT): increments on a token, clears on a data word.
  - idle_cnt: clears on a token, otherwise increments.
- **Alignment FSM** (state register, reset state SEARCH):
  - SEARCH:
    - If tok_cnt reaches TOKEN_COUNT → LOCKED; locked=1 from the next cycle.
    - Otherwise, if idle_cnt reaches TIMEOUT-1 → SLIP.
  - SLIP (1 cycle): offset ← (offset==9) ? 0 : offset+1; tok_cnt and idle_cnt cleared → FLUSH.
  - FLUSH (2 cycles): counters held at 0 while the pipeline refills with the new offset → SEARCH.
  - LOCKED: if idle_cnt reaches TIMEOUT-1 → SEARCH. Offset is kept, tok_cnt and idle_cnt are cleared, and locked falls on the next cycle.
  - Data words do not break lock. Only token absence does.
- **Simultaneous events:** if a token arrives in the cycle idle_cnt would reach TIMEOUT-1, the token wins (idle_cnt clears, no SLIP or lock loss).
- **Outputs while unlocked:** data=0, c=0, de=0. The decode pipeline keeps running internally.

## Timing
- All outputs are registered. Reset values: data=0, c=0, de=0, locked=0, offset=0. Internal state: SEARCH, prev=0, win=0, both counters 0.
- **Latency:** raw sampled at edge N reaches data/c/de at edge N+2 (N+1 → win, N+2 → outputs).
- **Lock timing:** with the correct offset and tokens from edge N, locked=1 at edge N+1+TOKEN_COUNT+1.
- **Slip cost:** one SLIP plus FLUSH costs 3 cycles. A full sweep of all offsets is bounded by 10·(TIMEOUT+3) cycles.
- **Reset mid-operation:** reset asserted in any state returns the block to reset values on the next edge. Offset is not retained.
- **Locked/de relationship:** the locked rise and the first gated-through output occur on the same edge.

## Test plan
- **Aligned tokens:** reset, then continuous 10'b1101010100 at offset 0 → locked=1 at cycle TOKEN_COUNT+2, offset=0, c=00, de=0.
- **Misaligned stream:** token stream rotated by 3 bits, TIMEOUT=16 → offset steps 0→1→2→3, then locked=1. Offset never exceeds 3.
- **Data decode:** while locked, words 10'h100, 10'h200, and the encoded value of 8'hA5 → data 8'h00, 8'hFF, 8'hA5 with de=1, each two cycles after input.
- **Control mapping:** all four tokens in sequence → c=00,01,10,11 with de=0. A following data word leaves c unchanged.
- **Lock loss:** locked, then TIMEOUT cycles of 10'h100 only → locked falls to 0 with offset unchanged. Tokens resume → relock without any SLIP.
- **Reset during LOCKED at offset 5:** rst=0 for one edge → all outputs 0 and offset=0 on the next edge.

Source files
------------

// File: rtl/tmds_channel_decoder.sv
// TMDS receive channel: recovers the 10-bit word boundary from control tokens
// with an internal barrel shifter, then decodes pixel bytes and control bits.
module tmds_channel_decoder #(
  parameter int TOKEN_COUNT = 8,
  parameter int TIMEOUT     = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] raw,
  output logic [7:0] data,
  output logic [1:0] c,
  output logic       de,
  output logic       locked,
  output logic [3:0] offset,
  output logic [1:0] dbg_state
);
  localparam int TOK_W  = $clog2(TOKEN_COUNT + 1);
  localparam int IDLE_W = $clog2(TIMEOUT);
  localparam logic [TOK_W-1:0]  TOK_MAX  = TOK_W'(TOKEN_COUNT);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_SLIP   = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_LOCKED = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_flush;
  logic [9:0]         r_prev;
  logic [9:0]         r_win;
  logic [3:0]         r_offset;
  logic [TOK_W-1:0]   r_tok_cnt;
  logic [IDLE_W-1:0]  r_idle_cnt;
  logic [1:0]         r_last_c;
  logic [7:0]         r_data;
  logic [1:0]         r_c;
  logic               r_de;
  logic               r_locked;

  logic [19:0]        w_cat;
  logic [4:0]         w_sel;
  logic [9:0]         w_aligned;
  logic               w_is_tok;
  logic [1:0]         w_tok_c;
  logic [7:0]         w_d;
  logic [7:0]         w_decoded;
  logic               w_timeout;
  logic               w_lock_nxt;
  logic               w_cnt_clr;

  // Barrel shifter: two consecutive raw words cover every possible boundary.
  assign w_cat     = {raw, r_prev};
  assign w_sel     = {1'b0, r_offset};
  assign w_aligned = w_cat[w_sel +: 10];

  always_comb begin
    w_is_tok = 1'b1;
    w_tok_c  = 2'b00;
    case (r_win)
      10'b1101010100: w_tok_c = 2'b00;
      10'b0010101011: w_tok_c = 2'b01;
      10'b0101010100: w_tok_c = 2'b10;
      10'b1010101011: w_tok_c = 2'b11;
      default:        w_is_tok = 1'b0;
    endcase
  end

  assign w_d = r_win[9] ? ~r_win[7:0] : r_win[7:0];

  always_comb begin
    w_decoded    = 8'd0;
    w_decoded[0] = w_d[0];
    for (int i = 1; i < 8; i++) begin
      w_decoded[i] = r_win[8] ? (w_d[i] ^ w_d[i-1]) : ~(w_d[i] ^ w_d[i-1]);
    end
  end

  // A token in the timeout cycle wins over slip / lock loss.
  assign w_timeout = (r_idle_cnt == IDLE_MAX) && !w_is_tok;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_SEARCH: begin
        if (r_tok_cnt == TOK_MAX) w_state_nxt = ST_LOCKED;
        else if (w_timeout)       w_state_nxt = ST_SLIP;
      end
      ST_SLIP:   w_state_nxt = ST_FLUSH;
      ST_FLUSH:  if (r_flush) w_state_nxt = ST_SEARCH;
      ST_LOCKED: if (w_timeout) w_state_nxt = ST_SEARCH;
      default:   w_state_nxt = ST_SEARCH;
    endcase
  end

  assign w_lock_nxt = (w_state_nxt == ST_LOCKED);
  assign w_cnt_clr  = (r_state == ST_SLIP) || (r_state == ST_FLUSH) || w_timeout;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ST_SEARCH;
      r_flush    <= 1'b0;
      r_prev     <= 10'd0;
      r_win      <= 10'd0;
      r_offset   <= 4'd0;
      r_tok_cnt  <= '0;
      r_idle_cnt <= '0;
      r_last_c   <= 2'b00;
      r_data     <= 8'd0;
      r_c        <= 2'b00;
      r_de       <= 1'b0;
      r_locked   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_flush <= (r_state == ST_FLUSH) && !r_flush;
      r_prev  <= raw;
      r_win   <= w_aligned;
      if (r_state == ST_SLIP) begin
        r_offset <= (r_offset == 4'd9) ? 4'd0 : r_offset + 4'd1;
      end
      if (w_cnt_clr) begin
        r_tok_cnt  <= '0;
        r_idle_cnt <= '0;
      end else if (w_is_tok) begin
        r_tok_cnt  <= (r_tok_cnt == TOK_MAX) ? TOK_MAX : r_tok_cnt + TOK_W'(1);
        r_idle_cnt <= '0;
      end else begin
        r_tok_cnt  <= '0;
        r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
      end
      if (w_is_tok) r_last_c <= w_tok_c;
      // Outputs are gated with the next lock value so the rise lines up.
      r_locked <= w_lock_nxt;
      r_de     <= w_lock_nxt && !w_is_tok;
      r_data   <= (w_lock_nxt && !w_is_tok) ? w_decoded : 8'd0;
      r_c      <= w_lock_nxt ? (w_is_tok ? w_tok_c : r_last_c) : 2'b00;
    end
  end

  assign data      = r_data;
  assign c         = r_c;
  assign de        = r_de;
  assign locked    = r_locked;
  assign offset    = r_offset;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Bench for tmds_channel_decoder: directed scenarios plus randomized streams
// compared each cycle against a bit-stream level reference model.
module tb_tmds_channel_decoder;
  localparam int TC = 8;
  localparam int TO = 16;
  localparam logic [9:0] TOK0 = 10'b1101010100;
  localparam logic [9:0] TOK1 = 10'b0010101011;
  localparam logic [9:0] TOK2 = 10'b0101010100;
  localparam logic [9:0] TOK3 = 10'b1010101011;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [9:0] raw = 10'd0;
  logic [7:0] data;
  logic [1:0] c;
  logic       de;
  logic       locked;
  logic [3:0] offset;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  tmds_channel_decoder #(.TOKEN_COUNT(TC), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .raw(raw), .data(data), .c(c), .de(de),
    .locked(locked), .offset(offset), .dbg_state(dbg_state)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] exp_q[$];
  logic [9:0]  toks [4] = '{TOK0, TOK1, TOK2, TOK3};

  // ---------------- reference model ----------------
  logic [9:0] m_prev, m_win;
  logic [1:0] m_lastc;
  int         m_off, m_tok, m_idle, m_stall;
  bit         m_locked;

  function automatic int tok_code(input logic [9:0] w);
    for (int k = 0; k < 4; k++) if (w == toks[k]) return k;
    return -1;
  endfunction

  function automatic logic [7:0] ref_decode(input logic [9:0] w);
    logic [7:0] d, q;
    d    = w[7:0] ^ {8{w[9]}};
    q[0] = d[0];
    for (int i = 1; i < 8; i++) q[i] = d[i] ^ d[i-1] ^ ~w[8];
    return q;
  endfunction

  function automatic logic [9:0] encode_xor(input logic [7:0] v);
    logic [7:0] q;
    q[0] = v[0];
    for (int i = 1; i < 8; i++) q[i] = v[i] ^ q[i-1];
    return {2'b01, q};
  endfunction

  // Transmitted word stream shifted by r bits across word boundaries.
  function automatic logic [9:0] rot_word(input logic [9:0] cur, input logic [9:0] prv, input int r);
    logic [19:0] cat;
    cat = {cur, prv};
    cat = cat >> (10 - r);
    return cat[9:0];
  endfunction

  task automatic model_step(input logic rst_v, input logic [9:0] w);
    int         tk;
    bit         to, clr, nl;
    logic [19:0] cat;
    logic [9:0] aligned;
    logic [7:0] ed;
    logic [1:0] ec;
    bit         ede;
    if (!rst_v) begin
      m_prev = 0; m_win = 0; m_lastc = 0; m_off = 0; m_tok = 0; m_idle = 0;
      m_stall = 0; m_locked = 0;
      exp_q.push_back(16'h0000);
    end else begin
      tk      = tok_code(m_win);
      to      = (m_idle == TO - 1) && (tk < 0);
      cat     = {w, m_prev} >> m_off;
      aligned = cat[9:0];
      nl      = m_locked;
      clr     = 0;
      if (m_stall > 0) begin
        if (m_stall == 3) m_off = (m_off + 1) % 10;
        m_stall--;
        clr = 1;
      end else if (m_locked) begin
        if (to) begin nl = 0; clr = 1; end
      end else if (m_tok == TC) begin
        nl = 1;
      end else if (to) begin
        m_stall = 3;
        clr = 1;
      end
      if (clr) begin m_tok = 0; m_idle = 0; end
      else if (tk >= 0) begin m_tok = (m_tok < TC) ? m_tok + 1 : TC; m_idle = 0; end
      else begin m_tok = 0; m_idle++; end
      ed = 0; ec = 0; ede = 0;
      if (nl) begin
        if (tk >= 0) ec = 2'(tk);
        else begin ede = 1; ed = ref_decode(m_win); ec = m_lastc; end
      end
      if (tk >= 0) m_lastc = 2'(tk);
      exp_q.push_back({nl, 4'(m_off), ede, ec, ed});
      m_prev   = w;
      m_win    = aligned;
      m_locked = nl;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_outputs();
    logic [15:0] e;
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check("locked", 32'(locked), 32'(e[15]));
      check("offset", 32'(offset), 32'(e[14:11]));
      check("de",     32'(de),     32'(e[10]));
      check("c",      32'(c),      32'(e[9:8]));
      check("data",   32'(data),   32'(e[7:0]));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic [9:0] w);
    raw = w;
    @(posedge clk);
    model_step(rst, w);
    #1;
    compare_outputs();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cycle(10'd0);
    cycle(10'd0);
    rst = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data"},   32'(data),   32'd0);
    check({tag, "_c"},      32'(c),      32'd0);
    check({tag, "_de"},     32'(de),     32'd0);
    check({tag, "_locked"}, 32'(locked), 32'd0);
    check({tag, "_offset"}, 32'(offset), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [9:0] s_cur, s_prev, w;
    int         r, max_off, n, kind, len;

    do_reset();
    check_all_zero("reset");

    // Aligned token stream: lock on the TC+2'th edge after the first token.
    for (int i = 0; i < TC + 2; i++) cycle(TOK0);
    check("lock_early", 32'(locked), 32'd0);
    cycle(TOK0);
    check("lock_at_tc2", 32'(locked), 32'd1);
    check("lock_offset", 32'(offset), 32'd0);
    check("lock_c", 32'(c), 32'd0);
    check("lock_de", 32'(de), 32'd0);

    // Data decode, two cycles of latency.
    cycle(10'h100);
    cycle(10'h200);
    cycle(encode_xor(8'hA5));
    check("dec_100", 32'(data), 32'h00);
    check("dec_100_de", 32'(de), 32'd1);
    cycle(TOK0);
    check("dec_200", 32'(data), 32'hFF);
    cycle(TOK0);
    check("dec_a5", 32'(data), 32'hA5);
    check("dec_a5_de", 32'(de), 32'd1);
    cycle(TOK0);
    check("dec_tok_de", 32'(de), 32'd0);

    // Control mapping; a data word keeps the last c.
    cycle(TOK1);
    cycle(TOK2);
    cycle(TOK3);
    check("ctl_01", 32'(c), 32'd1);
    cycle(10'h100);
    check("ctl_10", 32'(c), 32'd2);
    cycle(TOK0);
    check("ctl_11", 32'(c), 32'd3);
    check("ctl_11_de", 32'(de), 32'd0);
    cycle(TOK0);
    check("ctl_hold", 32'(c), 32'd3);
    check("ctl_hold_de", 32'(de), 32'd1);
    cycle(TOK0);
    check("ctl_00", 32'(c), 32'd0);

    // Lock loss through token absence, then relock at the same offset.
    for (int i = 0; i < TO; i++) cycle(10'h100);
    check("data_keeps_lock", 32'(locked), 32'd1);
    for (int i = 0; i < 4; i++) cycle(10'h100);
    check("lock_lost", 32'(locked), 32'd0);
    check("lost_offset", 32'(offset), 32'd0);
    for (int i = 0; i < TC + 4; i++) cycle(TOK0);
    check("relock", 32'(locked), 32'd1);
    check("relock_offset", 32'(offset), 32'd0);

    // Stream rotated by 3 bits: offsets sweep up to 3 and lock.
    do_reset();
    max_off = 0;
    n = 0;
    while (!locked && n < 200) begin
      cycle(rot_word(TOK0, TOK0, 3));
      if (int'(offset) > max_off) max_off = int'(offset);
      n++;
    end
    check("misalign_lock", 32'(locked), 32'd1);
    check("misalign_offset", 32'(offset), 32'd3);
    check("misalign_max_off_le3", 32'(max_off <= 3), 32'd1);

    // Lock at offset 5, then reset for one edge.
    do_reset();
    n = 0;
    while (!locked && n < 300) begin
      cycle(rot_word(TOK2, TOK2, 5));
      n++;
    end
    check("off5_lock", 32'(locked), 32'd1);
    check("off5_offset", 32'(offset), 32'd5);
    for (int i = 0; i < 3; i++) cycle(rot_word(TOK2, TOK2, 5));
    rst = 1'b0;
    cycle(rot_word(TOK2, TOK2, 5));
    rst = 1'b1;
    check_all_zero("midreset");

    // Randomized streams at random rotations.
    for (int seg = 0; seg < 2; seg++) begin
      do_reset();
      r = $urandom_range(0, 9);
      s_prev = 10'd0;
      n = 0;
      while (n < 700) begin
        kind = $urandom_range(0, 9);
        if (kind < 5)      len = $urandom_range(1, 12);
        else if (kind < 8) len = $urandom_range(1, 12);
        else               len = $urandom_range(10, 40);
        for (int i = 0; i < len; i++) begin
          if (kind < 5) s_cur = toks[$urandom_range(0, 3)];
          else          s_cur = 10'($urandom_range(0, 1023));
          w = rot_word(s_cur, s_prev, r);
          s_prev = s_cur;
          cycle(w);
          n++;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
